// File: rtl/pulse_scheduler.sv
// Round-robin scheduler that shares one pulse line among NREQ requesters.
// Optional statistics ports (pulse_count, overrun) are enabled by PULSE_SCHED_STATS_EN.
module pulse_scheduler #(
  parameter int NREQ = 4,
  parameter int WW   = 4,
  parameter int GAP  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WW-1:0]   width_in,
  output logic                 signal,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy
`ifdef PULSE_SCHED_STATS_EN
  ,
  output logic [15:0]          pulse_count,
  output logic                 overrun
`endif
);

  localparam int LW = $clog2(NREQ);
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_DONE, ST_GAP} state_t;

  state_t          state;
  logic [WW-1:0]   cnt;
  logic [GW-1:0]   gap_cnt;
  logic [LW-1:0]   last;

  logic [WW-1:0]   widths [NREQ];
  logic            pick_valid;
  logic [LW-1:0]   pick_idx;
  logic [WW-1:0]   pick_w;
  logic [NREQ-1:0] pick_oh;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_width
      assign widths[gi] = width_in[gi*WW +: WW];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester after last wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = LW'(idx);
      end
    end
  end

  assign pick_w  = widths[pick_idx];
  assign pick_oh = NREQ'(1) << pick_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      gap_cnt     <= '0;
      last        <= LW'(NREQ - 1);
      signal      <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      busy        <= 1'b0;
`ifdef PULSE_SCHED_STATS_EN
      pulse_count <= '0;
      overrun     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt    <= pick_oh;
            cnt    <= (pick_w == '0) ? WW'(1) : pick_w;
            last   <= pick_idx;
            signal <= 1'b1;
            busy   <= 1'b1;
            state  <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (cnt == WW'(1)) begin
            signal <= 1'b0;
            done   <= gnt;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt - WW'(1);
          end
        end
        ST_DONE: begin
          done <= '0;
          gnt  <= '0;
`ifdef PULSE_SCHED_STATS_EN
          pulse_count <= pulse_count + 16'd1;
          if ((req & ~gnt) != '0) overrun <= 1'b1;
`endif
          if (GAP > 0) begin
            gap_cnt <= GW'(GAP);
            state   <= ST_GAP;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt <= GW'(1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
